wave_flow_ctrl: RTL and testbench
=================================

WAVE_FLOW_CTRL -- requirements
Module: wave_flow_ctrl

Interface
REQ-001 SHALL have parameter ADDR_NBIT, default 24, SDRAM word-address width.
REQ-002 SHALL have parameter SDRAM_NBIT, default 32, SDRAM data width; SDRAM_NBIT >= DAC_NBIT.
REQ-003 SHALL have parameter DAC_NBIT, default 20, DAC sample width.
REQ-004 SHALL have parameter DIV_NBIT, default 16, sample-rate divider width.
REQ-005 SHALL have port mclk  input  1  main clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse; begins load then playback.
REQ-008 SHALL have port stop  input  1  one-cycle pulse; aborts load or playback.
REQ-009 SHALL have port cfg_len  input  ADDR_NBIT  waveform length in samples; 0 treated as 1.
REQ-010 SHALL have port cfg_div  input  DIV_NBIT  samples every cfg_div+1 mclk cycles.
REQ-011 SHALL have port cfg_loops  input  16  playback repetitions; 0 = loop forever.
REQ-012 SHALL have port ld_dv  input  1  load sample valid.
REQ-013 SHALL have port ld_data  input  DAC_NBIT  load sample.
REQ-014 SHALL have port ld_ready  output  1  block accepts ld_data this cycle.
REQ-015 SHALL have port sdram_wren  output  1  SDRAM write strobe.
REQ-016 SHALL have port sdram_waddr  output  ADDR_NBIT  SDRAM write address.
REQ-017 SHALL have port sdram_wdata  output  SDRAM_NBIT  ld_data zero-extended.
REQ-018 SHALL have port sdram_wstatus  input  1  HIGH = write buffer has room.
REQ-019 SHALL have port sdram_rd  output  1  SDRAM read strobe.
REQ-020 SHALL have port sdram_raddr  output  ADDR_NBIT  SDRAM read address.
REQ-021 SHALL have ports sdram_rdata  input  SDRAM_NBIT  and sdram_rdv  input  1  read data and valid.
REQ-022 SHALL have port sdram_rstatus  input  1  HIGH = read buffer has room.
REQ-023 SHALL have ports dac_start  output  1  sample tick; dac_dv  output  1; dac_data  output  DAC_NBIT.
REQ-024 SHALL have port done  output  1  one-cycle pulse at playback completion or stop.

Function
REQ-025 SHALL implement FSM IDLE -> LOAD -> PLAY -> IDLE; cfg_* latched on start in IDLE; start ignored outside IDLE.
REQ-026 SHALL, in LOAD, assert ld_ready = sdram_wstatus; on ld_dv&ld_ready assert sdram_wren next cycle with waddr = sample index from 0.
REQ-027 SHALL leave LOAD for PLAY the cycle after the write of index len-1; both counters wrap to 0 on entry to PLAY.
REQ-028 SHALL run divider counter only in PLAY, counting 0..cfg_div; dac_start = 1 when counter = 0 (cfg_div=0 -> every cycle).
REQ-029 SHALL assert sdram_rd = dac_start & sdram_rstatus; raddr increments per rd, wraps len-1 -> 0.
REQ-030 SHALL decrement loop counter on each wrap; when cfg_loops>0 and last sample of last loop read, go IDLE and pulse done.
REQ-031 SHALL skip a tick (no rd, raddr held) when dac_start & !sdram_rstatus (underrun).
REQ-032 SHALL pass dac_dv = sdram_rdv, dac_data = sdram_rdata[DAC_NBIT-1:0] combinationally in any state.
REQ-033 SHALL, on stop in LOAD or PLAY, go IDLE next cycle, drop ld_ready/rd/wren, pulse done; stop has priority over simultaneous start/ld_dv.

Reset
REQ-034 SHALL on rst_n low asynchronously: state IDLE, all counters and addresses 0, sdram_wren, sdram_rd, ld_ready, dac_start, done = 0; reset mid-LOAD/PLAY discards progress.

Configuration
REQ-035 SHALL, with WAVE_UNDERRUN_CNT_EN defined, add output underrun_cnt [15:0] counting REQ-031 events, saturating at 65535, cleared on start; without it, no port and no counter.

Verification
REQ-036 SHALL cover: len=4, div=0, loops=2, data 1..4 -> 4 writes addr 0..3, then 8 reads raddr 0,1,2,3,0,1,2,3, one done pulse.
REQ-037 SHALL cover: div=3 -> dac_start every 4th cycle in PLAY, none in IDLE/LOAD.
REQ-038 SHALL cover: sdram_wstatus low 5 cycles mid-load -> ld_ready low, no wren, waddr resumes unchanged.
REQ-039 SHALL cover: rstatus low over 2 ticks, loops=0 -> 2 skipped reads, raddr held, underrun_cnt=2 when macro defined.
REQ-040 SHALL cover: stop during PLAY and rst_n low mid-LOAD -> IDLE, outputs at reset/idle values, fresh start reloads from addr 0.

Source files
------------

// File: rtl/wave_flow_ctrl.sv
// Waveform playback controller: loads DAC samples into SDRAM, then replays them at a divided rate.
// Optional WAVE_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module wave_flow_ctrl #(
  parameter int ADDR_NBIT  = 24,
  parameter int SDRAM_NBIT = 32,
  parameter int DAC_NBIT   = 20,
  parameter int DIV_NBIT   = 16
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_NBIT-1:0]  cfg_len,
  input  logic [DIV_NBIT-1:0]   cfg_div,
  input  logic [15:0]           cfg_loops,
  input  logic                  ld_dv,
  input  logic [DAC_NBIT-1:0]   ld_data,
  output logic                  ld_ready,
  output logic                  sdram_wren,
  output logic [ADDR_NBIT-1:0]  sdram_waddr,
  output logic [SDRAM_NBIT-1:0] sdram_wdata,
  input  logic                  sdram_wstatus,
  output logic                  sdram_rd,
  output logic [ADDR_NBIT-1:0]  sdram_raddr,
  input  logic [SDRAM_NBIT-1:0] sdram_rdata,
  input  logic                  sdram_rdv,
  input  logic                  sdram_rstatus,
  output logic                  dac_start,
  output logic                  dac_dv,
  output logic [DAC_NBIT-1:0]   dac_data,
  output logic                  done
`ifdef WAVE_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_NBIT-1:0]  len_q, len_d, wcnt_q, wcnt_d, rcnt_q, rcnt_d, waddr_q, waddr_d;
  logic [DIV_NBIT-1:0]   div_q, div_d, dcnt_q, dcnt_d;
  logic [15:0]           loop_q, loop_d;
  logic                  inf_q, inf_d, wren_q, wren_d, done_q, done_d;
  logic [SDRAM_NBIT-1:0] wdata_q, wdata_d;
  logic                  to_idle;
  logic                  unused_rdata;

  // wcnt reaching len means every sample has been accepted; hold off further loads.
  assign ld_ready  = (state_q == S_LOAD) && sdram_wstatus && !stop && (wcnt_q != len_q);
  assign dac_start = (state_q == S_PLAY) && (dcnt_q == '0);
  assign sdram_rd  = dac_start && sdram_rstatus && !stop;

  assign sdram_wren   = wren_q;
  assign sdram_waddr  = waddr_q;
  assign sdram_wdata  = wdata_q;
  assign sdram_raddr  = rcnt_q;
  assign done         = done_q;
  assign dac_dv       = sdram_rdv;
  assign dac_data     = sdram_rdata[DAC_NBIT-1:0];
  assign unused_rdata = ^sdram_rdata;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    div_d   = div_q;
    loop_d  = loop_q;
    inf_d   = inf_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    dcnt_d  = dcnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;
    done_d  = 1'b0;
    to_idle = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          len_d   = (cfg_len == '0) ? ADDR_NBIT'(1) : cfg_len;
          div_d   = cfg_div;
          loop_d  = cfg_loops;
          inf_d   = (cfg_loops == '0);
          wcnt_d  = '0;
          rcnt_d  = '0;
          dcnt_d  = '0;
        end
      end
      S_LOAD: begin
        if (stop) begin
          to_idle = 1'b1;
        end else begin
          if (ld_dv && ld_ready) begin
            wren_d  = 1'b1;
            waddr_d = wcnt_q;
            wdata_d = SDRAM_NBIT'(ld_data);
            wcnt_d  = wcnt_q + ADDR_NBIT'(1);
          end
          if (wren_q && (waddr_q == len_q - ADDR_NBIT'(1))) begin
            state_d = S_PLAY;
            wcnt_d  = '0;
            rcnt_d  = '0;
            dcnt_d  = '0;
          end
        end
      end
      S_PLAY: begin
        if (stop) begin
          to_idle = 1'b1;
        end else begin
          dcnt_d = (dcnt_q == div_q) ? '0 : dcnt_q + DIV_NBIT'(1);
          // An underrun tick issues no read, so raddr simply holds.
          if (sdram_rd) begin
            if (rcnt_q == len_q - ADDR_NBIT'(1)) begin
              rcnt_d = '0;
              if (!inf_q) begin
                if (loop_q == 16'd1) to_idle = 1'b1;
                else                 loop_d  = loop_q - 16'd1;
              end
            end else begin
              rcnt_d = rcnt_q + ADDR_NBIT'(1);
            end
          end
        end
      end
      default: to_idle = 1'b1;
    endcase
    if (to_idle) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      wren_d  = 1'b0;
      wcnt_d  = '0;
      rcnt_d  = '0;
      dcnt_d  = '0;
      waddr_d = '0;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      div_q   <= '0;
      loop_q  <= '0;
      inf_q   <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      dcnt_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      div_q   <= div_d;
      loop_q  <= loop_d;
      inf_q   <= inf_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      dcnt_q  <= dcnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
    end
  end

`ifdef WAVE_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if ((state_q == S_IDLE) && start)
      ucnt_d = '0;
    else if (dac_start && !sdram_rstatus && (ucnt_q != 16'hFFFF))
      ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_wave_flow_ctrl.sv
// Self-checking bench for wave_flow_ctrl: directed scenarios plus randomized load/playback runs.
module tb_wave_flow_ctrl;
  localparam int AW = 24, SW = 32, DW = 20, VW = 16;

  logic          mclk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [AW-1:0] cfg_len = '0;
  logic [VW-1:0] cfg_div = '0;
  logic [15:0]   cfg_loops = '0;
  logic          ld_dv = 1'b0, ld_ready;
  logic [DW-1:0] ld_data = '0;
  logic          sdram_wren, sdram_wstatus = 1'b1, sdram_rd, sdram_rdv = 1'b0, sdram_rstatus = 1'b1;
  logic [AW-1:0] sdram_waddr, sdram_raddr;
  logic [SW-1:0] sdram_wdata, sdram_rdata = '0;
  logic          dac_start, dac_dv, done;
  logic [DW-1:0] dac_data;
`ifdef WAVE_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  wave_flow_ctrl #(.ADDR_NBIT(AW), .SDRAM_NBIT(SW), .DAC_NBIT(DW), .DIV_NBIT(VW)) dut (
    .mclk(mclk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_div(cfg_div), .cfg_loops(cfg_loops),
    .ld_dv(ld_dv), .ld_data(ld_data), .ld_ready(ld_ready),
    .sdram_wren(sdram_wren), .sdram_waddr(sdram_waddr), .sdram_wdata(sdram_wdata),
    .sdram_wstatus(sdram_wstatus), .sdram_rd(sdram_rd), .sdram_raddr(sdram_raddr),
    .sdram_rdata(sdram_rdata), .sdram_rdv(sdram_rdv), .sdram_rstatus(sdram_rstatus),
    .dac_start(dac_start), .dac_dv(dac_dv), .dac_data(dac_data), .done(done)
`ifdef WAVE_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 mclk = ~mclk;

  int n_chk = 0, n_fail = 0;

  // Observation log, written only by the monitor; tasks request a clear by bumping gen.
  int cyc = 0, gen = 0, seen_gen = 0;
  int wr_addr[$], wr_data[$], wr_cyc[$], rd_addr[$], tick_cyc[$];
  int done_cnt = 0, skip_cnt = 0;
  int exp_data[$];

  always @(negedge mclk) begin
    cyc++;
    if (gen != seen_gen) begin
      seen_gen = gen;
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); rd_addr.delete(); tick_cyc.delete();
      done_cnt = 0; skip_cnt = 0;
    end
    if (sdram_wren) begin
      wr_addr.push_back(int'(sdram_waddr)); wr_data.push_back(int'(sdram_wdata)); wr_cyc.push_back(cyc);
    end
    if (sdram_rd) rd_addr.push_back(int'(sdram_raddr));
    if (dac_start) begin
      tick_cyc.push_back(cyc);
      if (!sdram_rstatus) skip_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge mclk); #1;
  endtask

  task automatic clear_mon();
    gen++;
    exp_data.delete();
  endtask

  task automatic pulse_start(input int len, input int div, input int loops);
    cfg_len = len[AW-1:0]; cfg_div = div[VW-1:0]; cfg_loops = loops[15:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Loader model: LOAD begins the cycle after start, ready follows wstatus until len samples accepted.
  task automatic run_play(input int len, input int div, input int loops, input bit rnd_w,
                          input bit rnd_r, input bit seq, input int budget, output bit to);
    int n, eff_len;
    eff_len = (len == 0) ? 1 : len;
    clear_mon();
    tick();
    pulse_start(len, div, loops);
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      ld_dv         = rnd_w ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld_data       = seq ? DW'(exp_data.size() + 1) : DW'($urandom);
      sdram_wstatus = rnd_w ? ($urandom_range(0, 3) != 0) : 1'b1;
      sdram_rstatus = rnd_r ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ld_dv && sdram_wstatus && exp_data.size() < eff_len) exp_data.push_back(int'(ld_data));
      tick();
      n++;
    end
    to = (done_cnt == 0);
    ld_dv = 1'b0; sdram_wstatus = 1'b1; sdram_rstatus = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    obs = {ld_ready, sdram_wren, sdram_rd, dac_start, done, |sdram_waddr, |sdram_raddr};
    n_chk++;
    if (obs !== 7'b0) begin n_fail++; $display("FAIL reset_outputs got %b want 0000000", obs); end
`ifdef WAVE_UNDERRUN_CNT_EN
    n_chk++;
    if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_underrun got %0d want 0", underrun_cnt); end
`endif
    #2 rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 4; i++) begin
      logic [SW-1:0] d;
      logic [DW-1:0] lo;
      d = $urandom; lo = d[DW-1:0];
      sdram_rdata = d; sdram_rdv = i[0];
      #1;
      n_chk++;
      if (dac_data !== lo || dac_dv !== i[0]) begin
        n_fail++; $display("FAIL passthrough got %h/%b want %h/%b", dac_data, dac_dv, lo, i[0]);
      end
    end
    sdram_rdv = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit to;
    run_play(4, 0, 2, 1'b0, 1'b0, 1'b1, 500, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL basic_timeout got no done want done"); end
    n_chk++;
    if (wr_addr.size() !== 4) begin n_fail++; $display("FAIL basic_nwrites got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      n_chk++;
      if (wr_addr[i] !== i || wr_data[i] !== i + 1) begin
        n_fail++; $display("FAIL basic_write%0d got a%0d d%0d want a%0d d%0d", i, wr_addr[i], wr_data[i], i, i + 1);
      end
    end
    n_chk++;
    if (rd_addr.size() !== 8) begin n_fail++; $display("FAIL basic_nreads got %0d want 8", rd_addr.size()); end
    for (int i = 0; i < 8 && i < rd_addr.size(); i++) begin
      n_chk++;
      if (rd_addr[i] !== i % 4) begin n_fail++; $display("FAIL basic_raddr%0d got %0d want %0d", i, rd_addr[i], i % 4); end
    end
    n_chk++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_div();
    bit to;
    run_play(2, 3, 3, 1'b0, 1'b0, 1'b0, 500, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL div_timeout got no done want done"); end
    n_chk++;
    if (tick_cyc.size() !== 6) begin n_fail++; $display("FAIL div_nticks got %0d want 6", tick_cyc.size()); end
    for (int i = 1; i < tick_cyc.size(); i++) begin
      n_chk++;
      if (tick_cyc[i] - tick_cyc[i-1] !== 4) begin
        n_fail++; $display("FAIL div_spacing%0d got %0d want 4", i, tick_cyc[i] - tick_cyc[i-1]);
      end
    end
    if (tick_cyc.size() > 0 && wr_cyc.size() > 0) begin
      n_chk++;
      if (tick_cyc[0] !== wr_cyc[wr_cyc.size()-1] + 1) begin
        n_fail++; $display("FAIL div_first_tick got %0d want %0d", tick_cyc[0], wr_cyc[wr_cyc.size()-1] + 1);
      end
    end
  endtask

  task automatic test_wstall();
    int acc;
    clear_mon();
    tick();
    pulse_start(8, 0, 1);
    acc = 0;
    for (int c = 0; c < 60 && done_cnt == 0; c++) begin
      sdram_wstatus = !(c >= 3 && c < 8);
      ld_dv = 1'b1; ld_data = DW'($urandom);
      if (sdram_wstatus && acc < 8) begin exp_data.push_back(int'(ld_data)); acc++; end
      #3;
      if (c >= 3 && c < 8) begin
        n_chk++;
        if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL wstall_ready c%0d got %b want 0", c, ld_ready); end
        if (c >= 4) begin
          n_chk++;
          if (sdram_wren !== 1'b0) begin n_fail++; $display("FAIL wstall_wren c%0d got %b want 0", c, sdram_wren); end
        end
      end
      tick();
    end
    ld_dv = 1'b0; sdram_wstatus = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (wr_addr.size() !== 8) begin n_fail++; $display("FAIL wstall_nwrites got %0d want 8", wr_addr.size()); end
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      n_chk++;
      if (wr_addr[i] !== i || wr_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL wstall_write%0d got a%0d d%0h want a%0d d%0h", i, wr_addr[i], wr_data[i], i, exp_data[i]);
      end
    end
    n_chk++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL wstall_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_underrun_stop();
    int nt, ns;
    bit to;
    logic [5:0] obs;
    clear_mon();
    tick();
    pulse_start(3, 1, 0);
    nt = 0; ns = 0;
    for (int c = 0; c < 40; c++) begin
      ld_dv = 1'b1; ld_data = DW'($urandom);
      if (dac_start) begin
        nt++;
        if (nt >= 3 && ns < 2) begin sdram_rstatus = 1'b0; ns++; end
        else sdram_rstatus = 1'b1;
      end else begin
        sdram_rstatus = (ns == 1) ? 1'b0 : 1'b1;
      end
      tick();
    end
    ld_dv = 1'b0; sdram_rstatus = 1'b1;
    n_chk++;
    if (skip_cnt !== 2) begin n_fail++; $display("FAIL underrun_skips got %0d want 2", skip_cnt); end
    n_chk++;
    if (rd_addr.size() !== tick_cyc.size() - 2) begin
      n_fail++; $display("FAIL underrun_nreads got %0d want %0d", rd_addr.size(), tick_cyc.size() - 2);
    end
    for (int i = 0; i < rd_addr.size(); i++) begin
      n_chk++;
      if (rd_addr[i] !== i % 3) begin n_fail++; $display("FAIL underrun_raddr%0d got %0d want %0d", i, rd_addr[i], i % 3); end
    end
    n_chk++;
    if (done_cnt !== 0) begin n_fail++; $display("FAIL forever_done got %0d want 0", done_cnt); end
`ifdef WAVE_UNDERRUN_CNT_EN
    n_chk++;
    if (underrun_cnt !== 16'd2) begin n_fail++; $display("FAIL underrun_cnt got %0d want 2", underrun_cnt); end
`endif
    stop = 1'b1;
    #1;
    n_chk++;
    if (sdram_rd !== 1'b0) begin n_fail++; $display("FAIL stop_rd got %b want 0", sdram_rd); end
    tick();
    stop = 1'b0;
    obs = {ld_ready, sdram_wren, sdram_rd, dac_start, |sdram_raddr, |sdram_waddr};
    n_chk++;
    if (done !== 1'b1 || obs !== 6'b0) begin n_fail++; $display("FAIL stop_idle got done=%b %b want done=1 000000", done, obs); end
    tick();
    n_chk++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL stop_done_pulse got %b want 0", done); end
    run_play(2, 0, 1, 1'b0, 1'b0, 1'b1, 200, to);
    n_chk++;
    if (to || wr_addr.size() !== 2 || rd_addr.size() !== 2) begin
      n_fail++; $display("FAIL restart_after_stop got w%0d r%0d to%0d want w2 r2 to0", wr_addr.size(), rd_addr.size(), to);
    end else begin
      n_chk++;
      if (wr_addr[0] !== 0 || wr_addr[1] !== 1 || rd_addr[0] !== 0 || rd_addr[1] !== 1) begin
        n_fail++; $display("FAIL restart_addrs got w%0d,%0d r%0d,%0d want 0,1", wr_addr[0], wr_addr[1], rd_addr[0], rd_addr[1]);
      end
    end
`ifdef WAVE_UNDERRUN_CNT_EN
    n_chk++;
    if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL underrun_clear got %0d want 0", underrun_cnt); end
`endif
  endtask

  task automatic test_reset_midload();
    bit to;
    logic [6:0] obs;
    clear_mon();
    tick();
    pulse_start(6, 0, 1);
    for (int c = 0; c < 3; c++) begin ld_dv = 1'b1; ld_data = DW'(c + 9); tick(); end
    #2 rst_n = 1'b0;
    #1;
    obs = {ld_ready, sdram_wren, sdram_rd, dac_start, done, |sdram_waddr, |sdram_raddr};
    n_chk++;
    if (obs !== 7'b0) begin n_fail++; $display("FAIL midload_reset got %b want 0000000", obs); end
    ld_dv = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_play(2, 0, 1, 1'b0, 1'b0, 1'b1, 200, to);
    n_chk++;
    if (to || wr_addr.size() !== 2 || rd_addr.size() !== 2 || done_cnt !== 1) begin
      n_fail++; $display("FAIL midload_restart got w%0d r%0d d%0d want w2 r2 d1", wr_addr.size(), rd_addr.size(), done_cnt);
    end else begin
      n_chk++;
      if (wr_addr[0] !== 0 || wr_addr[1] !== 1 || wr_data[0] !== 1 || wr_data[1] !== 2) begin
        n_fail++; $display("FAIL midload_writes got a%0d,%0d d%0d,%0d want a0,1 d1,2", wr_addr[0], wr_addr[1], wr_data[0], wr_data[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len, div, loops, eff;
      bit to;
      len = (it == 0) ? 0 : $urandom_range(1, 6);
      div = $urandom_range(0, 3);
      loops = $urandom_range(1, 3);
      eff = (len == 0) ? 1 : len;
      run_play(len, div, loops, 1'b1, 1'b1, 1'b0, 3000, to);
      n_chk++;
      if (to) begin n_fail++; $display("FAIL rnd%0d_timeout got no done want done", it); end
      n_chk++;
      if (wr_addr.size() !== eff) begin n_fail++; $display("FAIL rnd%0d_nwrites got %0d want %0d", it, wr_addr.size(), eff); end
      for (int i = 0; i < wr_addr.size() && i < exp_data.size(); i++) begin
        n_chk++;
        if (wr_addr[i] !== i || wr_data[i] !== exp_data[i]) begin
          n_fail++; $display("FAIL rnd%0d_write%0d got a%0d d%0h want a%0d d%0h", it, i, wr_addr[i], wr_data[i], i, exp_data[i]);
        end
      end
      n_chk++;
      if (rd_addr.size() !== eff * loops) begin
        n_fail++; $display("FAIL rnd%0d_nreads got %0d want %0d", it, rd_addr.size(), eff * loops);
      end
      for (int i = 0; i < rd_addr.size(); i++) begin
        n_chk++;
        if (rd_addr[i] !== i % eff) begin n_fail++; $display("FAIL rnd%0d_raddr%0d got %0d want %0d", it, i, rd_addr[i], i % eff); end
      end
      for (int i = 1; i < tick_cyc.size(); i++) begin
        n_chk++;
        if (tick_cyc[i] - tick_cyc[i-1] !== div + 1) begin
          n_fail++; $display("FAIL rnd%0d_spacing%0d got %0d want %0d", it, i, tick_cyc[i] - tick_cyc[i-1], div + 1);
        end
      end
      n_chk++;
      if (tick_cyc.size() !== rd_addr.size() + skip_cnt || done_cnt !== 1) begin
        n_fail++; $display("FAIL rnd%0d_ticks got t%0d d%0d want t%0d d1", it, tick_cyc.size(), done_cnt, rd_addr.size() + skip_cnt);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge mclk);
    #1;
    test_reset();
    test_passthrough();
    test_basic();
    test_div();
    test_wstall();
    test_underrun_stop();
    test_reset_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
